// File: rtl/dcp_mem_pkg.sv
// Shared types and constants for the accelerator memory request/response interface.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package dcp_mem_pkg;

  localparam int PADDR_W     = 40;
  localparam int TRANSID_W   = 6;
  localparam int LINE_BYTES  = 64;
  localparam int RESP_DATA_W = 512;
  localparam int LINE_OFS_W  = 6;

  typedef struct packed {
    logic [TRANSID_W-1:0] transid;
    logic [PADDR_W-1:0]   addr;
  } mem_req_t;

  typedef struct packed {
    logic [TRANSID_W-1:0]   transid;
    logic [RESP_DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/dcp_lat_pipe.sv
// Fixed-delay valid/payload shift register carrying responses to the output.
// Latency: LATENCY edges from in_vld_i to out_vld_o (stage 0 loads on the input edge).
// Backpressure: none; advances every cycle, clr_i drops everything in flight.
module dcp_lat_pipe #(
  parameter int LATENCY = 4,
  parameter int W       = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o
);

  logic [LATENCY-1:0] vld_q;
  logic [W-1:0]       dat_q [LATENCY];

  // Shift valid and payload one stage per cycle; empty slots carry zero payload.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      dat_q[0] <= in_vld_i ? in_dat_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld_o = vld_q[LATENCY-1];
  assign out_dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/dcp_mem_responder.sv
// Memory-side responder: returns a 64 B line from a preloadable store for each request.
// Latency: response visible LATENCY cycles after the accept cycle, in accept order.
// Backpressure: registered rdy caps in-flight requests at MAX_OUTSTANDING; responses cannot stall.
module dcp_mem_responder
  import dcp_mem_pkg::*;
#(
  parameter int LINE_IDX_W      = 10,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_val,
  output logic                   mem_req_rdy,
  input  logic [TRANSID_W-1:0]   mem_req_transid,
  input  logic [PADDR_W-1:0]     mem_req_addr,
  output logic                   mem_resp_val,
  output logic [TRANSID_W-1:0]   mem_resp_transid,
  output logic [RESP_DATA_W-1:0] mem_resp_data,
  input  logic                   ld_en,
  input  logic [LINE_IDX_W-1:0]  ld_idx,
  input  logic [RESP_DATA_W-1:0] ld_data,
  output logic [6:0]             outstanding,
  output logic                   err_dup_transid
);

  localparam int         DEPTH     = 1 << LINE_IDX_W;
  localparam logic [6:0] MAX_OUT_W = 7'(MAX_OUTSTANDING);

  logic [RESP_DATA_W-1:0] store_q [DEPTH];

  mem_req_t              req;
  logic [LINE_IDX_W-1:0] req_idx;
  logic                  accept;
  mem_resp_t             pipe_in;
  mem_resp_t             pipe_out;
  logic                  pipe_vld;

  logic                  rdy_q, rdy_d;
  logic [6:0]            outstanding_q, outstanding_d;
  logic [63:0]           inflight_q, inflight_d;
  logic                  err_q, err_d;

  // Offset and aliasing bits of the address play no part in line selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req.addr[PADDR_W-1:LINE_OFS_W+LINE_IDX_W], req.addr[LINE_OFS_W-1:0]};

  assign req     = '{transid: mem_req_transid, addr: mem_req_addr};
  assign req_idx = req.addr[LINE_OFS_W +: LINE_IDX_W];
  assign accept  = mem_req_val && rdy_q;

  // Line is read combinationally in the accept cycle, so a same-cycle preload is not seen.
  assign pipe_in = '{transid: req.transid, data: store_q[req_idx]};

  // Preload port: always accepted, store contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) store_q[ld_idx] <= ld_data;
  end

  dcp_lat_pipe #(
    .LATENCY (LATENCY),
    .W       ($bits(mem_resp_t))
  ) u_lat_pipe (
    .clk_i     (clk),
    .clr_i     (rst),
    .in_vld_i  (accept),
    .in_dat_i  (pipe_in),
    .out_vld_o (pipe_vld),
    .out_dat_o (pipe_out)
  );

  assign mem_resp_val     = pipe_vld;
  assign mem_resp_transid = pipe_out.transid;
  assign mem_resp_data    = pipe_out.data;

  // Next-state for occupancy, in-flight tags, duplicate flag and ready.
  always_comb begin
    outstanding_d = outstanding_q;
    inflight_d    = inflight_q;
    err_d         = err_q;
    if (accept && !pipe_vld)      outstanding_d = outstanding_q + 7'd1;
    else if (!accept && pipe_vld) outstanding_d = outstanding_q - 7'd1;
    // Clear before set: a tag retiring and re-entering in one cycle stays set.
    if (pipe_vld) inflight_d[pipe_out.transid] = 1'b0;
    if (accept) begin
      if (inflight_q[req.transid] && !(pipe_vld && pipe_out.transid == req.transid))
        err_d = 1'b1;
      inflight_d[req.transid] = 1'b1;
    end
    rdy_d = (outstanding_d < MAX_OUT_W);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q         <= 1'b0;
      outstanding_q <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      rdy_q         <= rdy_d;
      outstanding_q <= outstanding_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
    end
  end

  assign mem_req_rdy     = rdy_q;
  assign outstanding     = outstanding_q;
  assign err_dup_transid = err_q;

endmodule

// File: tb/tb_dcp_mem_responder.sv
// Bench for dcp_mem_responder: directed scenarios plus random traffic against a queue-based model.
// Latency: model predicts response visibility LAT cycles after each accept cycle.
// Backpressure: model derives ready from its own pending-response count.
module tb_dcp_mem_responder;
  import dcp_mem_pkg::*;

  localparam int IDXW = 10;
  localparam int LAT  = 4;
  localparam int MAXO = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_req_val;
  logic           mem_req_rdy;
  logic [5:0]     mem_req_transid;
  logic [39:0]    mem_req_addr;
  logic           mem_resp_val;
  logic [5:0]     mem_resp_transid;
  logic [511:0]   mem_resp_data;
  logic           ld_en;
  logic [IDXW-1:0] ld_idx;
  logic [511:0]   ld_data;
  logic [6:0]     outstanding;
  logic           err_dup_transid;

  always #5 clk = ~clk;

  dcp_mem_responder #(
    .LINE_IDX_W      (IDXW),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .ld_en            (ld_en),
    .ld_idx           (ld_idx),
    .ld_data          (ld_data),
    .outstanding      (outstanding),
    .err_dup_transid  (err_dup_transid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a list of pending responses, each with the edge after which it shows.
  typedef struct {
    int           due;
    logic [5:0]   tid;
    logic [511:0] data;
  } exp_t;

  exp_t         q[$];
  logic [511:0] mdl_mem [1024];
  logic         mdl_rdy = 1'b0, mdl_err = 1'b0, mdl_acc = 1'b0, was_rst = 1'b0;
  logic         exp_val = 1'b0;
  logic [5:0]   exp_tid = '0;
  logic [511:0] exp_data = '0;
  int           ecnt = 0;
  int           resp_seen = 0;
  int           max_out = 0;
  logic [511:0] pat5;

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_edge();
    exp_t e;
    ecnt++;
    mdl_acc = 1'b0;
    was_rst = rst;
    if (rst) begin
      q.delete();
      mdl_rdy = 1'b0; mdl_err = 1'b0; exp_val = 1'b0; exp_tid = '0; exp_data = '0;
    end else begin
      if (q.size() > 0 && q[0].due == ecnt - 1) void'(q.pop_front());
      if (mem_req_val && mdl_rdy) begin
        mdl_acc = 1'b1;
        foreach (q[i]) if (q[i].tid == mem_req_transid) mdl_err = 1'b1;
        e.due  = ecnt + LAT - 1;
        e.tid  = mem_req_transid;
        e.data = mdl_mem[int'(mem_req_addr[6 +: IDXW])];
        q.push_back(e);
      end
      mdl_rdy = (q.size() < MAXO);
      exp_val = (q.size() > 0 && q[0].due == ecnt);
      if (exp_val) begin exp_tid = q[0].tid; exp_data = q[0].data; end
    end
    if (ld_en) mdl_mem[ld_idx] = ld_data;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    chk("rdy", 512'(mem_req_rdy), 512'(mdl_rdy));
    chk("resp_val", 512'(mem_resp_val), 512'(exp_val));
    chk("outstanding", 512'(outstanding), 512'(q.size()));
    chk("err_dup", 512'(err_dup_transid), 512'(mdl_err));
    if (exp_val || was_rst) begin
      chk("resp_tid", 512'(mem_resp_transid), 512'(exp_val ? exp_tid : 6'd0));
      chk("resp_data", mem_resp_data, exp_val ? exp_data : 512'd0);
    end
    if (mem_resp_val) resp_seen++;
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
  endtask

  task automatic idle();
    mem_req_val = 1'b0;
    ld_en       = 1'b0;
  endtask

  task automatic req(input logic [5:0] tid, input logic [39:0] addr);
    mem_req_val     = 1'b1;
    mem_req_transid = tid;
    mem_req_addr    = addr;
  endtask

  task automatic ld(input logic [IDXW-1:0] idx, input logic [511:0] data);
    ld_en   = 1'b1;
    ld_idx  = idx;
    ld_data = data;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int r0, first, acc_n, guard;
    logic saw_low;
    logic [511:0] line_a, line_b;

    rst = 1'b1;
    idle();
    mem_req_transid = '0; mem_req_addr = '0; ld_idx = '0; ld_data = '0;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
    pat5 = {64{8'h05}};
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // Preload lines 0..15; line 5 holds 0x05 in every byte.
    for (int i = 0; i < 16; i++) begin
      ld(IDXW'(i), (i == 5) ? pat5 : rnd_line());
      cycle();
    end
    idle();
    cycle();

    // Single request: exactly one response, LAT cycles after the accept cycle.
    r0 = resp_seen;
    req(6'd3, 40'h140);
    cycle();
    idle();
    first = 0;
    for (int n = 1; n <= LAT + 3; n++) begin
      if (mem_resp_val && first == 0) begin
        first = n;
        chk("t1_tid", 512'(mem_resp_transid), 512'(3));
        chk("t1_data", mem_resp_data, pat5);
      end
      cycle();
    end
    chk("t1_latency", 512'(first), 512'(LAT));
    chk("t1_count", 512'(resp_seen - r0), 512'(1));

    // Eight back-to-back requests held until accepted; cap limits occupancy.
    r0 = resp_seen; max_out = 0; acc_n = 0; saw_low = 1'b0; guard = 0;
    while (acc_n < 8 && guard < 200) begin
      req(6'(acc_n), 40'(acc_n) << 6);
      cycle();
      if (mdl_acc) acc_n++;
      if (!mem_req_rdy) saw_low = 1'b1;
      guard++;
    end
    drain(LAT + 4);
    chk("t2_accepted", 512'(acc_n), 512'(8));
    chk("t2_rdy_dropped", 512'(saw_low), 512'(1));
    chk("t2_max_out_ok", 512'(max_out <= MAXO), 512'(1));
    chk("t2_resp_count", 512'(resp_seen - r0), 512'(8));

    // Offset ignored and upper address bits alias to line 5.
    r0 = resp_seen;
    req(6'd10, 40'h17F);
    cycle();
    req(6'd11, 40'h140 + (40'h1 << 16));
    cycle();
    idle();
    for (int n = 0; n < LAT + 3; n++) begin
      if (mem_resp_val) chk("t3_alias_data", mem_resp_data, pat5);
      cycle();
    end
    chk("t3_count", 512'(resp_seen - r0), 512'(2));

    // Read-first: same-cycle preload not seen, following request sees it.
    line_a = rnd_line();
    line_b = ~line_a;
    ld(10'd9, line_a);
    cycle();
    ld(10'd9, line_b);
    req(6'd12, 40'h9 << 6);
    cycle();
    ld_en = 1'b0;
    req(6'd13, 40'h9 << 6);
    cycle();
    idle();
    for (int n = 0; n < LAT + 3; n++) begin
      if (mem_resp_val && mem_resp_transid == 6'd12) chk("t4_old_data", mem_resp_data, line_a);
      if (mem_resp_val && mem_resp_transid == 6'd13) chk("t4_new_data", mem_resp_data, line_b);
      cycle();
    end

    // Tag re-accepted in the very cycle its response fires: not a duplicate.
    req(6'd7, 40'h0);
    cycle();
    idle();
    for (int n = 0; n < LAT - 1; n++) cycle();
    chk("e0_resp_val", 512'(mem_resp_val), 512'(1));
    chk("e0_resp_tid", 512'(mem_resp_transid), 512'(7));
    req(6'd7, 40'h40);
    cycle();
    idle();
    chk("e0_err", 512'(err_dup_transid), 512'(0));
    drain(LAT + 3);

    // True duplicate: sticky error, both requests still answered.
    r0 = resp_seen;
    req(6'd7, 40'h40);
    cycle();
    req(6'd7, 40'h80);
    cycle();
    idle();
    chk("dup_err", 512'(err_dup_transid), 512'(1));
    drain(LAT + 3);
    chk("dup_resp_count", 512'(resp_seen - r0), 512'(2));
    chk("dup_err_sticky", 512'(err_dup_transid), 512'(1));

    // Reset with three in flight: all dropped, store kept.
    for (int i = 0; i < 3; i++) begin
      req(6'(20 + i), 40'(i) << 6);
      cycle();
    end
    idle();
    rst = 1'b1;
    cycle();
    chk("rst_rdy", 512'(mem_req_rdy), 512'(0));
    chk("rst_outstanding", 512'(outstanding), 512'(0));
    chk("rst_err", 512'(err_dup_transid), 512'(0));
    rst = 1'b0;
    cycle();
    chk("rel_rdy", 512'(mem_req_rdy), 512'(1));
    r0 = resp_seen;
    drain(LAT + 4);
    chk("rst_no_resp", 512'(resp_seen - r0), 512'(0));
    req(6'd23, 40'h140);
    cycle();
    idle();
    first = 0;
    for (int n = 0; n < LAT + 3; n++) begin
      if (mem_resp_val) begin
        first = 1;
        chk("rst_store_kept", mem_resp_data, pat5);
      end
      cycle();
    end
    chk("rst_store_resp", 512'(first), 512'(1));

    // Random traffic with live preloads and occasional resets.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_req_val     = $urandom_range(0, 1) == 1;
      mem_req_transid = 6'($urandom_range(0, 63));
      mem_req_addr    = {18'($urandom), 6'd0, 4'($urandom_range(0, 15)), 6'($urandom)};
      ld_en           = ($urandom_range(0, 4) == 0);
      ld_idx          = IDXW'($urandom_range(0, 15));
      ld_data         = rnd_line();
      cycle();
    end
    rst = 1'b0;
    drain(LAT + 4);
    chk("end_outstanding", 512'(outstanding), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
